// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter_if
// Description : Requester/consumer bundle for the 4:1 mux round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_rr_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]    req;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic          out_ready;
    logic          s1;
    logic          s2;
    logic [3:0]    gnt;
    logic [DW-1:0] y;
    logic          out_valid;

    // Requesters and the downstream consumer.
    modport master (
        output req, a, b, c, d, out_ready,
        input  s1, s2, gnt, y, out_valid
    );

    // The arbiter itself.
    modport slave (
        input  req, a, b, c, d, out_ready,
        output s1, s2, gnt, y, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter/sequencer driving the shared 4:1 mux
//               selects, a one-hot grant and a valid/ready handshake.
//               Optional bursting is compiled in with MUX_ARB_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mux_rr_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_sel;
    logic [1:0] r_ptr;
    logic [3:0] r_gnt;

    logic       w_owner_req;
    logic       w_beat;
    logic       w_burst_cont;
    logic       w_rearb;
    logic [1:0] w_arb_start;
    logic [2:0] w_pick;
    logic       w_load;

    // Returns {found, index} of the first set bit scanning upward from start.
    function automatic logic [2:0] f_pick(input logic [3:0] rq, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + i[1:0];
            if (rq[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_owner_req = bus.req[r_sel];
    assign w_beat      = (r_state == S_XFER) && w_owner_req && bus.out_ready;

`ifdef MUX_ARB_BURST_EN
    localparam int c_cnt_w = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [c_cnt_w-1:0] r_cnt;

    assign w_burst_cont = w_owner_req && (r_cnt < c_cnt_w'(MAX_BURST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_beat && w_burst_cont) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_max_burst;

    assign w_burst_cont       = 1'b0;
    assign w_unused_max_burst = (MAX_BURST > 0);
`endif

    // Re-arbitration starts just past the current owner so it ranks last.
    assign w_rearb     = (r_state == S_XFER) && (!w_owner_req || (w_beat && !w_burst_cont));
    assign w_arb_start = (r_state == S_IDLE) ? r_ptr : (r_sel + 2'd1);
    assign w_pick      = f_pick(bus.req, w_arb_start);
    assign w_load      = ((r_state == S_IDLE) || w_rearb) && w_pick[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_gnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick[2]) begin
                        r_sel   <= w_pick[1:0];
                        r_gnt   <= 4'b0001 << w_pick[1:0];
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_beat) begin
                        r_ptr <= r_sel + 2'd1;
                    end
                    if (w_rearb) begin
                        if (w_pick[2]) begin
                            r_sel <= w_pick[1:0];
                            r_gnt <= 4'b0001 << w_pick[1:0];
                        end else begin
                            r_gnt   <= 4'd0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.s1        = r_sel[0];
    assign bus.s2        = r_sel[1];
    assign bus.gnt       = r_gnt;
    assign bus.out_valid = (r_state == S_XFER) && w_owner_req;

    always_comb begin
        bus.y = bus.a;
        case (r_sel)
            2'd0:    bus.y = bus.a;
            2'd1:    bus.y = bus.b;
            2'd2:    bus.y = bus.c;
            default: bus.y = bus.d;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Self-checking bench for mux_rr_arbiter against a reference
//               model; burst checks follow MUX_ARB_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
`ifdef MUX_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    mux_rr_arbiter_if #(.DW(DW)) bus ();

    mux_rr_arbiter #(
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference state: owner index or -1 when idle, plus beats done by owner.
    int m_owner;
    int m_sel;
    int m_ptr;
    int m_done;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] rq, input int start);
        for (int i = 0; i < 4; i++) begin
            if (rq[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] data_of(input int idx);
        case (idx)
            0:       return bus.a;
            1:       return bus.b;
            2:       return bus.c;
            default: return bus.d;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_ptr   = 0;
        m_done  = 0;
    endtask

    task automatic grant_or_idle(input int w);
        if (w >= 0) begin
            m_owner = w;
            m_sel   = w;
            m_done  = 0;
        end else begin
            m_owner = -1;
        end
    endtask

    task automatic model_step();
        if (m_owner < 0) begin
            grant_or_idle(pick(bus.req, m_ptr));
        end else if (!bus.req[m_owner]) begin
            grant_or_idle(pick(bus.req, (m_owner + 1) % 4));
        end else if (bus.out_ready) begin
            m_ptr = (m_owner + 1) % 4;
            m_done++;
            if (!(BURST_EN && m_done < MAX_BURST)) begin
                grant_or_idle(pick(bus.req, m_ptr));
            end
        end
    endtask

    task automatic model_check();
        logic [3:0] e_gnt;
        logic       e_valid;
        e_gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e_valid = (m_owner >= 0) && bus.req[m_owner];
        check_val("gnt", {28'd0, bus.gnt}, {28'd0, e_gnt});
        check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, e_valid});
        check_val("sel", {30'd0, bus.s2, bus.s1}, m_sel);
        check_val("y", {24'd0, bus.y}, {24'd0, data_of(m_sel)});
    endtask

    // One clock: check at the falling edge, advance model with the inputs the DUT saw.
    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_gnt(input logic [3:0] target, input string tag);
        for (int i = 0; i < 6 && bus.gnt !== target; i++) begin
            step();
        end
        check_val(tag, {28'd0, bus.gnt}, {28'd0, target});
    endtask

    task automatic async_reset_pulse();
        rst = 1'b1;
        #1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic set_data_random();
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.c = 8'($urandom);
        bus.d = 8'($urandom);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        bus.a         = 8'h11;
        bus.b         = 8'h22;
        bus.c         = 8'h33;
        bus.d         = 8'h44;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("idle_gnt", {28'd0, bus.gnt}, 32'd0);
            check_val("idle_valid", {31'd0, bus.out_valid}, 32'd0);
            check_val("idle_sel", {30'd0, bus.s2, bus.s1}, 32'd0);
            check_val("idle_y", {24'd0, bus.y}, 32'h11);
        end

        // All request, consumer always ready: strict rotation a,b,c,d,a.
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        step();
        if (!BURST_EN) begin
            for (int i = 0; i < 5; i++) begin
                check_val("rot_gnt", {28'd0, bus.gnt}, 32'd1 << (i % 4));
                check_val("rot_sel", {30'd0, bus.s2, bus.s1}, i % 4);
                check_val("rot_y", {24'd0, bus.y}, 32'h11 * ((i % 4) + 1));
                step();
            end
        end

        // Only c requests while the consumer stalls, then accepts.
        bus.req       = 4'b0100;
        bus.out_ready = 1'b0;
        wait_gnt(4'b0100, "stall_gnt");
        for (int i = 0; i < 3; i++) begin
            check_val("stall_sel", {30'd0, bus.s2, bus.s1}, 32'd2);
            check_val("stall_y", {24'd0, bus.y}, 32'h33);
            check_val("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        check_val("regrant_c", {28'd0, bus.gnt}, 32'b0100);

        // b owns, then drops while a and d request: d wins from start 2.
        bus.req       = 4'b0010;
        bus.out_ready = 1'b0;
        wait_gnt(4'b0010, "own_b");
        bus.req = 4'b1001;
        step();
        check_val("withdraw_d", {28'd0, bus.gnt}, 32'b1000);

        // Async reset during d's stalled beat.
        bus.req = 4'b1000;
        wait_gnt(4'b1000, "own_d");
        rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_gnt", {28'd0, bus.gnt}, 32'd0);
        check_val("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("rst_sel", {30'd0, bus.s2, bus.s1}, 32'd0);
        bus.req = 4'b0110;
        #2;
        rst = 1'b0;
        step();
        check_val("post_rst_b", {28'd0, bus.gnt}, 32'b0010);

`ifdef MUX_ARB_BURST_EN
        // Bursts of four per owner: a,a,a,a,b,b,b,b,a.
        bus.req = 4'b0000;
        async_reset_pulse();
        bus.req       = 4'b0011;
        bus.out_ready = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            check_val("burst_gnt", {28'd0, bus.gnt}, ((i / 4) % 2 == 0) ? 32'b0001 : 32'b0010);
            step();
        end
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset_pulse();
            end
            bus.req       = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            set_data_random();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
